piece_move_sequencer: RTL and testbench
=======================================

// Module: piece_move_sequencer
// PURPOSE
//  Owns the active tetromino (tetromino_ctrl) and sequences every change to it through the shared validity checker.
//  Arbitrates gravity ticks vs. player move requests, forms a candidate, registers it onto the checker port,
//  then commits, discards, or locks the piece from the checker verdict. Sits between input/timer logic and the field.
// PARAMETERS
//  SPAWN_X   3   spawn column of the piece's 4x4 box origin (signed coordinate)
//  SPAWN_Y   0   spawn row of the box origin
//  DROP_MAX  22  hard-drop step limit (= `FIELD_VERTICAL); reaching it forces a lock
// PORTS
//  clk           in   1                clock
//  reset         in   1                synchronous, active-high
//  spawn_req     in   1                request new piece (accepted only in S_IDLE)
//  spawn_piece   in   tetromino_t      shape data + idx of the piece to spawn
//  grav_tick     in   1                one-cycle gravity pulse
//  move_valid    in   1                player move request valid
//  move_op       in   move_op_t(3)     LEFT, RIGHT, ROT_CW, ROT_CCW, SOFT_DROP, HARD_DROP
//  move_ready    out  1                move accepted when move_valid & move_ready
//  chk_t_ctrl    out  tetromino_ctrl   registered candidate driven to the checker
//  chk_isValid   in   1                combinational checker verdict for chk_t_ctrl vs. the current field
//  cur_t_ctrl    out  tetromino_ctrl   committed active piece (renderer)
//  piece_active  out  1                cur_t_ctrl is meaningful
//  move_done     out  1                one-cycle pulse at the end of each player move
//  move_ok       out  1                qualifies move_done: 1 = committed, 0 = rejected
//  lock          out  1                one-cycle pulse: write cur_t_ctrl into the field this cycle
//  game_over     out  1                sticky until reset: spawn position invalid
// BEHAVIOUR
//  Reset: state S_IDLE. All outputs 0. cur_t_ctrl/chk_t_ctrl = 0. grav_pend = 0.
//  States:
//   S_IDLE:   spawn_req -> chk = {spawn_piece, rot 0, (SPAWN_X, SPAWN_Y)}; go S_SPAWN.
//   S_SPAWN:  isValid -> commit; piece_active = 1; go S_ACTIVE. Invalid -> S_OVER.
//   S_ACTIVE: grav_pend | grav_tick -> chk = cur with y+1; op = DOWN; go S_CHECK.
//             Else, if move_valid -> chk = move_apply(cur, move_op); go S_CHECK.
//   S_CHECK:  isValid -> cur <= chk.
//             Invalid with op DOWN/SOFT_DROP -> S_LOCK. Other invalid -> discard.
//             Then return to S_ACTIVE.
//   S_LOCK:   lock = 1 for 1 cycle; piece_active <= 0; go S_IDLE.
//   S_OVER:   absorbing state; game_over = 1.
//  move_ready = (state == S_ACTIVE) & ~grav_pend & ~grav_tick. Gravity wins same-cycle ties; the player op stalls.
//  grav_tick outside S_ACTIVE sets grav_pend (one-deep; extra ticks merge). Cleared when the DOWN check is issued.
//    grav_pend is also cleared on entry to S_IDLE.
//  Latency: player move = 2 cycles, accept -> move_done. move_done/move_ok are asserted in S_CHECK's exit cycle.
//    A SOFT_DROP that fails gives move_done with move_ok = 0, then lock on the next cycle.
//  Arithmetic: x, y are signed; x-1 at 0 yields -1, and the checker rejects it.
//    Rotation: ROT_CW = rot+1, ROT_CCW = rot-1, mod 4 (3+1 -> 0, 0-1 -> 3).
//  Field contents must stay constant between lock pulses. The checker is purely combinational on the registered chk_t_ctrl.
//  Reset mid-operation abandons any candidate with no lock pulse.
// CONFIGURATION
//  `HARD_DROP_EN defined: HARD_DROP enters S_DROP.
//    S_DROP repeats DOWN checks (2 cycles per step) and commits each valid step.
//    The first invalid step, or DROP_MAX steps, gives move_done & move_ok = 1, then S_LOCK.
//    grav_tick during S_DROP sets grav_pend, which is cleared on lock.
//  Undefined: HARD_DROP is accepted but gives move_done with move_ok = 0 after 2 cycles; cur is unchanged.
// STRUCTURE
//  Package additions in GLOBAL.sv: move_op_t enum, seq_state_t enum, SPAWN_X/SPAWN_Y defaults.
//  Sub-module move_apply (combinational): (tetromino_ctrl, move_op_t) -> candidate tetromino_ctrl.
//  The checker is instantiated by the parent, not inside this block.
// TESTING
//  1. Reset, spawn T on an empty field -> cur = (3,0), rot 0. piece_active = 1 two cycles after spawn_req.
//  2. LEFT x4 from x = 3 -> x = 2,1,0 each move_ok = 1. The 4th gives move_ok = 0 and x stays 0.
//  3. ROT_CCW at rot 0 -> rot 3. ROT_CW at rot 3 -> rot 0. Each move_done exactly 2 cycles after accept.
//  4. grav_tick and move_valid (RIGHT) in the same cycle -> move_ready = 0. y increments first, then x.
//     A tick during S_CHECK yields exactly one extra y+1.
//  5. Piece resting on a filled row, grav_tick -> DOWN rejected, lock pulse 1 cycle, piece_active = 0, state S_IDLE.
//  6. Filled spawn area, spawn_req -> game_over = 1 and stays 1 until reset.
//     With `HARD_DROP_EN, HARD_DROP from y = 0 on an empty field -> y = 18, then lock.

Source files
------------

// File: rtl/piece_move_sequencer_pkg.sv
// Shared types and constants for the active-piece move sequencer.
// Holds the piece/control structs, the move opcode enum, the sequencer
// state encoding and small coordinate helpers.
package piece_move_sequencer_pkg;

   // Playfield height; also the hard-drop step limit.
   localparam int FIELD_VERTICAL = 22;

   // Default spawn origin of the piece's 4x4 box.
   localparam int SPAWN_X_DEF = 3;
   localparam int SPAWN_Y_DEF = 0;

   // Signed coordinate width; -32..31 covers the field plus overhang.
   localparam int COORD_W = 6;

   // Player opcodes occupy 0..5; DOWN is the internal gravity step.
   typedef enum logic [2:0] {
      MOVE_LEFT      = 3'd0,
      MOVE_RIGHT     = 3'd1,
      MOVE_ROT_CW    = 3'd2,
      MOVE_ROT_CCW   = 3'd3,
      MOVE_SOFT_DROP = 3'd4,
      MOVE_HARD_DROP = 3'd5,
      MOVE_DOWN      = 3'd6
   } move_op_t;

   // Shape occupancy per rotation (bit r*4+c of the 4x4 box) plus piece index.
   typedef struct packed {
      logic [2:0]       idx;
      logic [3:0][15:0] shape;
   } tetromino_t;

   // Piece placement: shape, rotation and signed box origin.
   typedef struct packed {
      tetromino_t                t;
      logic [1:0]                rot;
      logic signed [COORD_W-1:0] x;
      logic signed [COORD_W-1:0] y;
   } tetromino_ctrl;

   // Sequencer state encoding.
   typedef logic [2:0] seq_state_t;
   localparam seq_state_t S_IDLE   = 3'd0;
   localparam seq_state_t S_SPAWN  = 3'd1;
   localparam seq_state_t S_ACTIVE = 3'd2;
   localparam seq_state_t S_CHECK  = 3'd3;
   localparam seq_state_t S_LOCK   = 3'd4;
   localparam seq_state_t S_OVER   = 3'd5;
   localparam seq_state_t S_DROP   = 3'd6;

   // One-step coordinate moves; wrap is harmless because the checker
   // rejects anything outside the field.
   function automatic logic signed [COORD_W-1:0] incCoord(input logic signed [COORD_W-1:0] v);
      return v + {{(COORD_W-1){1'b0}}, 1'b1};
   endfunction

   function automatic logic signed [COORD_W-1:0] decCoord(input logic signed [COORD_W-1:0] v);
      return v - {{(COORD_W-1){1'b0}}, 1'b1};
   endfunction

endpackage

// File: rtl/piece_move_sequencer_if.sv
// Bundle of all sequencer signals except clock and reset.
// master = the sequencer itself, slave = input/timer logic, checker and field.
interface piece_move_sequencer_if;
   import piece_move_sequencer_pkg::*;

   logic          spawn_req;
   tetromino_t    spawn_piece;
   logic          grav_tick;
   logic          move_valid;
   move_op_t      move_op;
   logic          move_ready;
   tetromino_ctrl chk_t_ctrl;
   logic          chk_isValid;
   tetromino_ctrl cur_t_ctrl;
   logic          piece_active;
   logic          move_done;
   logic          move_ok;
   logic          lock;
   logic          game_over;

   modport master (
      input  spawn_req, spawn_piece, grav_tick, move_valid, move_op, chk_isValid,
      output move_ready, chk_t_ctrl, cur_t_ctrl, piece_active, move_done, move_ok,
             lock, game_over
   );

   modport slave (
      output spawn_req, spawn_piece, grav_tick, move_valid, move_op, chk_isValid,
      input  move_ready, chk_t_ctrl, cur_t_ctrl, piece_active, move_done, move_ok,
             lock, game_over
   );

endinterface

// File: rtl/piece_move_sequencer_move_apply.sv
// Combinational candidate former: applies one move opcode to a placement.
// HARD_DROP_EN: when defined, HARD_DROP forms the first downward step;
// otherwise HARD_DROP leaves the placement untouched.
module piece_move_sequencer_move_apply
   import piece_move_sequencer_pkg::*;
(
   input  tetromino_ctrl curCtrl,
   input  move_op_t      op,
   output tetromino_ctrl candCtrl
);

   // Candidate = current placement with exactly one step applied
   always_comb begin
      candCtrl = curCtrl;
      case (op)
         MOVE_LEFT:      candCtrl.x   = decCoord(curCtrl.x);
         MOVE_RIGHT:     candCtrl.x   = incCoord(curCtrl.x);
         MOVE_ROT_CW:    candCtrl.rot = curCtrl.rot + 2'd1;
         MOVE_ROT_CCW:   candCtrl.rot = curCtrl.rot - 2'd1;
         MOVE_SOFT_DROP: candCtrl.y   = incCoord(curCtrl.y);
         MOVE_DOWN:      candCtrl.y   = incCoord(curCtrl.y);
`ifdef HARD_DROP_EN
         MOVE_HARD_DROP: candCtrl.y   = incCoord(curCtrl.y);
`else
         MOVE_HARD_DROP: candCtrl     = curCtrl;
`endif
         default:        candCtrl     = curCtrl;
      endcase
   end

endmodule

// File: rtl/piece_move_sequencer.sv
// Active-piece sequencer: owns the committed piece and routes every change
// through the external validity checker (registered candidate out,
// combinational verdict back). Gravity beats player moves on ties.
// Optional feature macro HARD_DROP_EN: HARD_DROP repeats DOWN steps until
// blocked or DROP_MAX steps, then locks. Without it HARD_DROP is rejected.
module piece_move_sequencer
   import piece_move_sequencer_pkg::*;
#(
   parameter int SPAWN_X  = SPAWN_X_DEF,
   parameter int SPAWN_Y  = SPAWN_Y_DEF,
   parameter int DROP_MAX = FIELD_VERTICAL
)(
   input logic                    clk,
   input logic                    reset,
   piece_move_sequencer_if.master bus
);

   // The drop counter is sized from DROP_MAX; keep it in a sane range.
   if (DROP_MAX < 1 || DROP_MAX > 63) begin : gBadDropMax
      $error("DROP_MAX must be in 1..63");
   end

   seq_state_t    state;
   tetromino_ctrl curCtrl;
   tetromino_ctrl chkCtrl;
   move_op_t      chkOp;
   logic          gravPend;
   logic          pieceActive;
   logic          moveDone;
   logic          moveOk;
   logic          lockPulse;
   logic          gameOver;

`ifdef HARD_DROP_EN
   localparam int CNT_W = $clog2(DROP_MAX + 1);
   localparam logic [CNT_W-1:0] DROP_LAST = CNT_W'(DROP_MAX - 1);
   logic [CNT_W-1:0] dropCnt;
   logic             dropIssue;
`endif

   logic          gravNow;
   logic          chkAccept;
   logic          lockOnReject;
   move_op_t      applyOp;
   tetromino_ctrl candCtrl;
   tetromino_ctrl spawnCtrl;

   assign gravNow      = bus.grav_tick | gravPend;
   // A disabled HARD_DROP never commits, whatever the checker says.
   assign chkAccept    = bus.chk_isValid && (chkOp != MOVE_HARD_DROP);
   assign lockOnReject = (chkOp == MOVE_DOWN) || (chkOp == MOVE_SOFT_DROP);

   // Player opcode only when a move can be taken; every other candidate is a DOWN step
   always_comb begin
      applyOp = MOVE_DOWN;
      if (state == S_ACTIVE && !gravNow) applyOp = bus.move_op;
   end

   // Spawn placement: new shape, rotation 0, at the configured origin
   always_comb begin
      spawnCtrl   = '0;
      spawnCtrl.t = bus.spawn_piece;
      spawnCtrl.x = COORD_W'(SPAWN_X);
      spawnCtrl.y = COORD_W'(SPAWN_Y);
   end

   piece_move_sequencer_move_apply uApply (
      .curCtrl  (curCtrl),
      .op       (applyOp),
      .candCtrl (candCtrl)
   );

   // Sequencer FSM, candidate/commit registers and one-cycle status pulses
   always_ff @(posedge clk) begin
      if (reset) begin
         state       <= S_IDLE;
         curCtrl     <= '0;
         chkCtrl     <= '0;
         chkOp       <= MOVE_DOWN;
         gravPend    <= 1'b0;
         pieceActive <= 1'b0;
         moveDone    <= 1'b0;
         moveOk      <= 1'b0;
         lockPulse   <= 1'b0;
         gameOver    <= 1'b0;
`ifdef HARD_DROP_EN
         dropCnt     <= '0;
         dropIssue   <= 1'b0;
`endif
      end else begin
         moveDone  <= 1'b0;
         moveOk    <= 1'b0;
         lockPulse <= 1'b0;
         // Ticks that arrive while busy are remembered once; extras merge.
         if (bus.grav_tick && state != S_ACTIVE) gravPend <= 1'b1;

         case (state)
            S_IDLE: begin
               if (bus.spawn_req) begin
                  chkCtrl <= spawnCtrl;
                  chkOp   <= MOVE_DOWN;
                  state   <= S_SPAWN;
               end
            end

            S_SPAWN: begin
               if (bus.chk_isValid) begin
                  curCtrl     <= chkCtrl;
                  pieceActive <= 1'b1;
                  state       <= S_ACTIVE;
               end else begin
                  gameOver <= 1'b1;
                  state    <= S_OVER;
               end
            end

            S_ACTIVE: begin
               if (gravNow) begin
                  chkCtrl  <= candCtrl;
                  chkOp    <= MOVE_DOWN;
                  gravPend <= 1'b0;
                  state    <= S_CHECK;
               end else if (bus.move_valid) begin
                  chkCtrl <= candCtrl;
                  chkOp   <= bus.move_op;
`ifdef HARD_DROP_EN
                  if (bus.move_op == MOVE_HARD_DROP) begin
                     dropCnt   <= '0;
                     dropIssue <= 1'b0;
                     state     <= S_DROP;
                  end else begin
                     state <= S_CHECK;
                  end
`else
                  state <= S_CHECK;
`endif
               end
            end

            S_CHECK: begin
               if (chkAccept) curCtrl <= chkCtrl;
               if (chkOp != MOVE_DOWN) begin
                  moveDone <= 1'b1;
                  moveOk   <= chkAccept;
               end
               if (!bus.chk_isValid && lockOnReject) state <= S_LOCK;
               else                                  state <= S_ACTIVE;
            end

            S_LOCK: begin
               lockPulse   <= 1'b1;
               pieceActive <= 1'b0;
               gravPend    <= 1'b0;
               state       <= S_IDLE;
            end

            S_OVER: begin
               state <= S_OVER;
            end

`ifdef HARD_DROP_EN
            // Alternates: evaluate the registered step, then issue the next one.
            S_DROP: begin
               if (dropIssue) begin
                  chkCtrl   <= candCtrl;
                  dropIssue <= 1'b0;
               end else if (bus.chk_isValid && dropCnt != DROP_LAST) begin
                  curCtrl   <= chkCtrl;
                  dropCnt   <= dropCnt + 1'b1;
                  dropIssue <= 1'b1;
               end else begin
                  if (bus.chk_isValid) curCtrl <= chkCtrl;
                  moveDone <= 1'b1;
                  moveOk   <= 1'b1;
                  state    <= S_LOCK;
               end
            end
`endif

            default: state <= S_IDLE;
         endcase
      end
   end

   assign bus.move_ready   = (state == S_ACTIVE) & ~gravPend & ~bus.grav_tick;
   assign bus.chk_t_ctrl   = chkCtrl;
   assign bus.cur_t_ctrl   = curCtrl;
   assign bus.piece_active = pieceActive;
   assign bus.move_done    = moveDone;
   assign bus.move_ok      = moveOk;
   assign bus.lock         = lockPulse;
   assign bus.game_over    = gameOver;

endmodule

// File: tb/tb_piece_move_sequencer.sv
// Directed bench for piece_move_sequencer with a field/checker model and a
// queue-based scoreboard for move_done and lock events.
`timescale 1ns/1ps
module tb_piece_move_sequencer;
   import piece_move_sequencer_pkg::*;

   logic clk = 1'b0;
   logic reset;
   always #5 clk = ~clk;

   piece_move_sequencer_if bus();

   piece_move_sequencer dut (
      .clk   (clk),
      .reset (reset),
      .bus   (bus)
   );

   // 10 x 22 field; T occupies box (1,2),(0,3),(1,3),(2,3) in every rotation.
   logic [9:0] field [22];
   tetromino_t tPiece;

   typedef struct {
      bit isLock;
      bit ok;
      int x;
      int y;
      int rot;
   } exp_t;
   exp_t expQ[$];

   int checks   = 0;
   int failures = 0;

   function automatic bit pieceFits(input tetromino_ctrl c);
      bit fits;
      int fx, fy;
      fits = 1'b1;
      for (int r = 0; r < 4; r++) begin
         for (int k = 0; k < 4; k++) begin
            if (c.t.shape[c.rot][r*4+k]) begin
               fx = int'($signed(c.x)) + k;
               fy = int'($signed(c.y)) + r;
               if (fx < 0 || fx >= 10 || fy >= 22) fits = 1'b0;
               else if (fy >= 0 && field[fy][fx]) fits = 1'b0;
            end
         end
      end
      return fits;
   endfunction

   always_comb begin
      bus.chk_isValid = 1'b0;
      bus.chk_isValid = pieceFits(bus.chk_t_ctrl);
   end

   task automatic check(input string name, input int actual, input int required);
      checks++;
      if (actual != required) begin
         failures++;
         $display("FAIL %s actual=%0d required=%0d", name, actual, required);
      end
   endtask

   // Scoreboard monitor
   always @(negedge clk) begin
      if (!reset && (bus.move_done || bus.lock)) begin
         if (expQ.size() == 0) begin
            check("unexpected_event", 1, 0);
         end else begin
            exp_t e;
            e = expQ.pop_front();
            check("event_is_lock", int'(bus.lock), int'(e.isLock));
            if (!e.isLock) check("done_ok", int'(bus.move_ok), int'(e.ok));
            check("event_x", int'($signed(bus.cur_t_ctrl.x)), e.x);
            check("event_y", int'($signed(bus.cur_t_ctrl.y)), e.y);
            check("event_rot", int'(bus.cur_t_ctrl.rot), e.rot);
         end
      end
   end

   task automatic tick();
      @(posedge clk);
      #1;
   endtask

   task automatic clearField();
      for (int r = 0; r < 22; r++) field[r] = '0;
   endtask

   task automatic doReset();
      reset = 1'b1;
      bus.spawn_req = 1'b0;
      bus.spawn_piece = tPiece;
      bus.grav_tick = 1'b0;
      bus.move_valid = 1'b0;
      bus.move_op = MOVE_LEFT;
      repeat (2) tick();
      reset = 1'b0;
   endtask

   task automatic spawnPiece(input bit expOk);
      bus.spawn_req = 1'b1;
      tick();
      bus.spawn_req = 1'b0;
      check("active_during_spawn", int'(bus.piece_active), 0);
      tick();
      check("piece_active", int'(bus.piece_active), int'(expOk));
      check("game_over", int'(bus.game_over), int'(!expOk));
      if (expOk) begin
         check("spawn_x", int'($signed(bus.cur_t_ctrl.x)), 3);
         check("spawn_y", int'($signed(bus.cur_t_ctrl.y)), 0);
         check("spawn_rot", int'(bus.cur_t_ctrl.rot), 0);
      end
   endtask

   task automatic doMove(input move_op_t op, input bit ok, input int x, input int y,
                         input int rot, input bit lockAfter, input bit tickInCheck,
                         input int latency);
      int n;
      n = 0;
      bus.move_valid = 1'b1;
      bus.move_op = op;
      while (!bus.move_ready && n < 20) begin
         tick();
         bus.grav_tick = 1'b0;
         n++;
      end
      if (!bus.move_ready) begin
         check("accept_timeout", 0, 1);
         bus.move_valid = 1'b0;
         return;
      end
      expQ.push_back('{isLock: 1'b0, ok: ok, x: x, y: y, rot: rot});
      if (lockAfter) expQ.push_back('{isLock: 1'b1, ok: 1'b0, x: x, y: y, rot: rot});
      tick();
      bus.move_valid = 1'b0;
      if (tickInCheck) bus.grav_tick = 1'b1;
      n = 1;
      while (!bus.move_done && n < 80) begin
         tick();
         bus.grav_tick = 1'b0;
         n++;
      end
      bus.grav_tick = 1'b0;
      check("move_done_seen", int'(bus.move_done), 1);
      if (latency > 0) check("move_latency", n, latency);
   endtask

   initial begin
      #2000000;
      $display("FAIL watchdog actual=timeout required=finish");
      $fatal(1, "watchdog");
   end

   initial begin
      tPiece.idx = 3'd5;
      for (int r = 0; r < 4; r++) tPiece.shape[r] = 16'h7200;
      clearField();

      // Reset state, spawn, edge moves and rotation wrap
      doReset();
      check("rst_piece_active", int'(bus.piece_active), 0);
      check("rst_move_done", int'(bus.move_done), 0);
      check("rst_move_ok", int'(bus.move_ok), 0);
      check("rst_lock", int'(bus.lock), 0);
      check("rst_game_over", int'(bus.game_over), 0);
      check("rst_move_ready", int'(bus.move_ready), 0);
      check("rst_cur_zero", int'(bus.cur_t_ctrl == '0), 1);
      check("rst_chk_zero", int'(bus.chk_t_ctrl == '0), 1);
      spawnPiece(1'b1);
      check("ready_after_spawn", int'(bus.move_ready), 1);
      doMove(MOVE_LEFT, 1'b1, 2, 0, 0, 1'b0, 1'b0, 2);
      doMove(MOVE_LEFT, 1'b1, 1, 0, 0, 1'b0, 1'b0, 2);
      doMove(MOVE_LEFT, 1'b1, 0, 0, 0, 1'b0, 1'b0, 2);
      doMove(MOVE_LEFT, 1'b0, 0, 0, 0, 1'b0, 1'b0, 2);
      doMove(MOVE_ROT_CCW, 1'b1, 0, 0, 3, 1'b0, 1'b0, 2);
      doMove(MOVE_ROT_CW, 1'b1, 0, 0, 0, 1'b0, 1'b0, 2);
      doMove(MOVE_ROT_CW, 1'b1, 0, 0, 1, 1'b0, 1'b0, 2);
      doMove(MOVE_ROT_CCW, 1'b1, 0, 0, 0, 1'b0, 1'b0, 2);
`ifdef HARD_DROP_EN
      doMove(MOVE_HARD_DROP, 1'b1, 0, 18, 0, 1'b1, 1'b0, 0);
      repeat (3) tick();
      check("hd_piece_active", int'(bus.piece_active), 0);
      check("hd_final_y", int'($signed(bus.cur_t_ctrl.y)), 18);
`else
      doMove(MOVE_HARD_DROP, 1'b0, 0, 0, 0, 1'b0, 1'b0, 2);
      tick();
      check("hd_off_y", int'($signed(bus.cur_t_ctrl.y)), 0);
      check("hd_off_active", int'(bus.piece_active), 1);
`endif

      // Gravity vs player tie, tick during check
      doReset();
      spawnPiece(1'b1);
      bus.grav_tick = 1'b1;
      bus.move_valid = 1'b1;
      bus.move_op = MOVE_RIGHT;
      #1;
      check("ready_tie", int'(bus.move_ready), 0);
      doMove(MOVE_RIGHT, 1'b1, 4, 1, 0, 1'b0, 1'b0, 2);
      doMove(MOVE_RIGHT, 1'b1, 5, 1, 0, 1'b0, 1'b1, 2);
      repeat (6) tick();
      check("pend_one_extra_y", int'($signed(bus.cur_t_ctrl.y)), 2);
      check("pend_cleared_ready", int'(bus.move_ready), 1);

      // Resting piece: failed soft drop and gravity both lock
      clearField();
      field[4] = '1;
      doReset();
      spawnPiece(1'b1);
      doMove(MOVE_SOFT_DROP, 1'b0, 3, 0, 0, 1'b1, 1'b0, 2);
      check("lock_not_with_done", int'(bus.lock), 0);
      tick();
      check("sd_lock_pulse", int'(bus.lock), 1);
      check("sd_inactive", int'(bus.piece_active), 0);
      tick();
      check("sd_lock_one_cycle", int'(bus.lock), 0);
      spawnPiece(1'b1);
      expQ.push_back('{isLock: 1'b1, ok: 1'b0, x: 3, y: 0, rot: 0});
      bus.grav_tick = 1'b1;
      tick();
      bus.grav_tick = 1'b0;
      repeat (2) tick();
      check("grav_lock_pulse", int'(bus.lock), 1);
      check("grav_inactive", int'(bus.piece_active), 0);
      check("grav_ready_idle", int'(bus.move_ready), 0);
      tick();
      check("grav_lock_one_cycle", int'(bus.lock), 0);
      spawnPiece(1'b1);
      check("respawn_no_pend", int'(bus.move_ready), 1);

      // Blocked spawn area: sticky game over
      clearField();
      field[2] = '1;
      field[3] = '1;
      doReset();
      spawnPiece(1'b0);
      repeat (5) tick();
      check("over_sticky", int'(bus.game_over), 1);
      bus.spawn_req = 1'b1;
      repeat (2) tick();
      bus.spawn_req = 1'b0;
      check("over_ignores_spawn", int'(bus.piece_active), 0);
      check("over_still_set", int'(bus.game_over), 1);
      doReset();
      check("over_cleared_by_reset", int'(bus.game_over), 0);

      tick();
      check("scoreboard_empty", expQ.size(), 0);
      $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
      $finish;
   end

endmodule
